collide_result_arbiter: RTL and testbench
=========================================

COLLIDE_RESULT_ARBITER -- requirements
Module: collide_result_arbiter

Interface
REQ-001 The block SHALL have parameter OUT_DEPTH, default 64, meaning the output-memory depth in 32-bit words; it is a multiple of 8 and at most 65536.
REQ-002 The block SHALL have port clk, input, 1 bit: the system clock; all logic is rising-edge.
REQ-003 The block SHALL have port rstmaster, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port req, input, 4 bits: req[i] requests a result write from collision engine i.
REQ-005 The block SHALL have ports bundle0..bundle3, input, 256 bits each: the 8-word result of engine i; word k is bits [32k+31:32k].
REQ-006 The block SHALL have port clear, input, 1 bit: synchronous request to rewind the write pointer.
REQ-007 The block SHALL have port ack, output, 4 bits: a one-cycle pulse on ack[i] when engine i's bundle is fully written.
REQ-008 The block SHALL have port mem_addr, output, 32 bits: the output-memory write address.
REQ-009 The block SHALL have port mem_wdata, output, 32 bits: the output-memory write data.
REQ-010 The block SHALL have port mem_we, output, 1 bit: the output-memory write enable.
REQ-011 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-012 The block SHALL have port full, output, 1 bit: high when fewer than 8 free words remain.
REQ-013 The block SHALL have port wr_ptr, output, 16 bits: the next free output word address.

Function
REQ-014 The block SHALL register every output.
REQ-015 The state machine SHALL have three states: IDLE, WRITE and ACK.
REQ-016 In IDLE, with clear=0, full=0 and req nonzero, the block SHALL, at the next edge:
- grant one requester by round-robin;
- latch that requester's bundle and index;
- enter WRITE.
REQ-017 Round-robin order SHALL search starting from the index after the last grant, wrapping 3->0; after reset the last grant is 3, so req=4'b1111 grants 0 first.
REQ-018 WRITE SHALL last exactly 8 cycles, k = 0..7:
- mem_we=1;
- mem_addr = wr_ptr_base + k, zero-extended;
- mem_wdata = latched word k.
REQ-019 The first mem_we=1 cycle SHALL be the cycle immediately after the grant edge, giving a latency of 1 cycle from a sampled req to the first write.
REQ-020 ACK SHALL last 1 cycle:
- mem_we=0;
- ack[granted]=1 and all other ack bits 0;
- wr_ptr advances by 8;
- next state is IDLE.
REQ-021 A requester SHALL deassert req in the cycle after it sees ack; the block ignores req while in WRITE and ACK.
REQ-022 Deassertion of req, or a change of bundle data, during WRITE SHALL NOT affect the write, because it uses the latched copy.
REQ-023 full SHALL equal (wr_ptr + 8 > OUT_DEPTH) and SHALL update in the same cycle wr_ptr changes.
REQ-024 While full=1, the block SHALL grant nothing and requests SHALL stall; there is no wrap-around.
REQ-025 When clear=1 in IDLE, the block SHALL, at the next edge:
- set wr_ptr=0 and full=0;
- make no grant in that cycle (clear wins over req).
REQ-026 clear outside IDLE SHALL be ignored and not remembered.
REQ-027 Outside WRITE, the block SHALL hold mem_we=0, mem_addr at its last value and mem_wdata at its last value.
REQ-028 ack SHALL be 0 in every state except ACK.

Reset
REQ-029 rstmaster=0 SHALL, immediately and asynchronously:
- force state=IDLE;
- force ack=0, mem_we=0, mem_addr=0, mem_wdata=0;
- force busy=0, full=0, wr_ptr=0;
- force the last grant to 3.
REQ-030 Reset asserted mid-WRITE SHALL abort the bundle without an ack; the engine re-requests after reset.
REQ-031 Release of rstmaster SHALL take effect on the first rising clk edge after release.

Verification
REQ-032 Scenario single request: req=4'b0100 with bundle2 words 0x20..0x27 -> addresses 0..7 written 0x20..0x27 on consecutive cycles, ack=4'b0100 for one cycle, wr_ptr=8.
REQ-033 Scenario fairness: req=4'b1111 held and re-raised after each ack -> grants in order 0,1,2,3,0, with wr_ptr bases 0,8,16,24,32.
REQ-034 Scenario full: OUT_DEPTH=16 with three requests -> two bundles written, full=1, the third engine stalls; clear -> wr_ptr=0, then the third bundle is written at 0..7.
REQ-035 Scenario data change: req dropped and bundle changed in WRITE cycle 3 -> all 8 latched words written unchanged and the ack still issued.
REQ-036 Scenario simultaneous: clear=1 and req=4'b0001 in the same IDLE cycle -> no mem_we that cycle, wr_ptr=0, grant follows one cycle later.
REQ-037 Scenario reset mid-operation: rstmaster low during WRITE cycle 5 -> mem_we=0 and wr_ptr=0 immediately, no ack; after release, req=4'b1000 is granted first.

Source files
------------

// File: rtl/collide_result_arbiter.sv
// ---------------------------------------------------------------------------
// collide_result_arbiter
//
// Purpose:
//   Collects 8-word result bundles from four collision engines. Requests are
//   served one at a time in round-robin order. A granted bundle is latched
//   and streamed into a linear output memory as 8 consecutive 32-bit writes,
//   starting at the current write pointer. A one-cycle ack then goes back to
//   the engine, and the pointer advances by 8. The pointer never wraps:
//   - when fewer than 8 free words remain, the block reports full and stalls
//     all requests;
//   - a clear in IDLE rewinds the pointer to 0.
//
// Ports:
//   clk          rising-edge system clock
//   rstmaster    asynchronous, active-low reset
//   req[3:0]     per-engine write request
//   bundle0..3   8-word result of each engine, word k at bits [32k+31:32k]
//   clear        synchronous rewind of the write pointer (honoured in IDLE)
//   ack[3:0]     one-cycle pulse when the granted engine's bundle is written
//   mem_addr     output-memory write address (zero-extended word address)
//   mem_wdata    output-memory write data
//   mem_we       output-memory write enable
//   busy         high whenever the state machine is not in IDLE
//   full         high when fewer than 8 free words remain
//   wr_ptr       next free output word address
// ---------------------------------------------------------------------------
module collide_result_arbiter #(
    parameter int OUT_DEPTH = 64
) (
    input  logic         clk,
    input  logic         rstmaster,
    input  logic [3:0]   req,
    input  logic [255:0] bundle0,
    input  logic [255:0] bundle1,
    input  logic [255:0] bundle2,
    input  logic [255:0] bundle3,
    input  logic         clear,
    output logic [3:0]   ack,
    output logic [31:0]  mem_addr,
    output logic [31:0]  mem_wdata,
    output logic         mem_we,
    output logic         busy,
    output logic         full,
    output logic [15:0]  wr_ptr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } state_t;

    // 18 bits hold OUT_DEPTH = 65536 plus the look-ahead of 16 words
    localparam logic [17:0] DEPTH = 18'(OUT_DEPTH);

    state_t         state;
    state_t         state_n;
    logic [1:0]     last_grant;
    logic [1:0]     grant_idx;
    logic [1:0]     cand;
    logic           grant_valid;
    logic           start;
    logic [255:0]   bundle_sel;
    logic [255:0]   bundle_q;
    logic [2:0]     word_cnt;
    // One bit wider than wr_ptr so that a completely filled 65536-word
    // memory does not alias back to address 0.
    logic [16:0]    ptr_q;
    logic [17:0]    ptr_adv;
    logic           full_after_adv;

    assign wr_ptr = ptr_q[15:0];

    // Round-robin search: start just after the last grant and wrap 3 -> 0.
    // The fourth candidate wraps to the last grant itself, so a lone repeat
    // requester is still served.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = last_grant;
        cand        = '0;
        for (int i = 1; i <= 4; i++) begin
            cand = last_grant + 2'(i);
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        case (grant_idx)
            2'd0:    bundle_sel = bundle0;
            2'd1:    bundle_sel = bundle1;
            2'd2:    bundle_sel = bundle2;
            default: bundle_sel = bundle3;
        endcase
    end

    // clear takes priority over any request, and a full memory stalls all
    assign start = (state == IDLE) && !clear && !full && grant_valid;

    // Fullness is evaluated on the advanced pointer so that full changes on
    // the same edge as wr_ptr
    assign ptr_adv        = {1'b0, ptr_q} + 18'd8;
    assign full_after_adv = (ptr_adv + 18'd8) > DEPTH;

    always_ff @(posedge clk or negedge rstmaster) begin
        if (!rstmaster) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // word_cnt wraps from 7 back to 0 on the edge that shows the last word.
    // Seeing 0 while in WRITE therefore means all 8 words are out.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = WRITE;
            WRITE:   if (word_cnt == 3'd0) state_n = ACK;
            ACK:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Registered datapath. Word 0 is issued on the grant edge itself, so
    // the first write appears one cycle after the request is sampled. The
    // bundle is latched on that edge, so later req/bundle changes are
    // harmless.
    always_ff @(posedge clk or negedge rstmaster) begin
        if (!rstmaster) begin
            last_grant <= 2'd3;
            bundle_q   <= '0;
            word_cnt   <= '0;
            ptr_q      <= '0;
            full       <= 1'b0;
            busy       <= 1'b0;
            ack        <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            busy <= (state_n != IDLE);
            case (state)
                IDLE: begin
                    if (clear) begin
                        ptr_q <= '0;
                        full  <= 1'b0;
                    end else if (start) begin
                        last_grant <= grant_idx;
                        bundle_q   <= bundle_sel;
                        mem_we     <= 1'b1;
                        mem_addr   <= {15'b0, ptr_q};
                        mem_wdata  <= bundle_sel[31:0];
                        word_cnt   <= 3'd1;
                    end
                end
                WRITE: begin
                    if (word_cnt != 3'd0) begin
                        mem_addr  <= {15'b0, ptr_q + 17'(word_cnt)};
                        mem_wdata <= bundle_q[{word_cnt, 5'b0} +: 32];
                        word_cnt  <= word_cnt + 3'd1;
                    end else begin
                        mem_we <= 1'b0;
                        ack    <= 4'b0001 << last_grant;
                        ptr_q  <= ptr_adv[16:0];
                        full   <= full_after_adv;
                    end
                end
                ACK: begin
                    ack <= '0;
                end
                default: begin
                    ack    <= '0;
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_collide_result_arbiter.sv
// ---------------------------------------------------------------------------
// tb_collide_result_arbiter
//
// Purpose:
//   Directed testbench for collide_result_arbiter. Two instances share every
//   input:
//   - dut_a uses the default depth of 64 words;
//   - dut_b uses a depth of 16 words, so that it fills up after two bundles.
//   Word k of engine e with tag t is {t, 8'h00, e[3:0], k[3:0]}.
// ---------------------------------------------------------------------------
module tb_collide_result_arbiter;

    logic         clk = 1'b0;
    logic         rstmaster = 1'b1;
    logic [3:0]   req = '0;
    logic         clear = 1'b0;
    logic [255:0] b0, b1, b2, b3;

    logic [3:0]   ack_a, ack_b;
    logic [31:0]  addr_a, addr_b, wdata_a, wdata_b;
    logic         we_a, we_b, busy_a, busy_b, full_a, full_b;
    logic [15:0]  ptr_a, ptr_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    collide_result_arbiter #(.OUT_DEPTH(64)) dut_a (
        .clk(clk), .rstmaster(rstmaster), .req(req),
        .bundle0(b0), .bundle1(b1), .bundle2(b2), .bundle3(b3),
        .clear(clear), .ack(ack_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
        .mem_we(we_a), .busy(busy_a), .full(full_a), .wr_ptr(ptr_a)
    );

    collide_result_arbiter #(.OUT_DEPTH(16)) dut_b (
        .clk(clk), .rstmaster(rstmaster), .req(req),
        .bundle0(b0), .bundle1(b1), .bundle2(b2), .bundle3(b3),
        .clear(clear), .ack(ack_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
        .mem_we(we_b), .busy(busy_b), .full(full_b), .wr_ptr(ptr_b)
    );

    function automatic logic [31:0] exp_word(input int eng, input logic [15:0] tag, input int k);
        return {tag, 8'h00, 4'(eng), 4'(k)};
    endfunction

    function automatic logic [255:0] make_bundle(input int eng, input logic [15:0] tag);
        logic [255:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) r[32*k +: 32] = exp_word(eng, tag, k);
        return r;
    endfunction

    // Advance to just after the next rising edge, where outputs are stable
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstmaster = 1'b0;
        req   = '0;
        clear = 1'b0;
        b0 = make_bundle(0, 16'h0000);
        b1 = make_bundle(1, 16'h0000);
        b2 = make_bundle(2, 16'h0000);
        b3 = make_bundle(3, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        rstmaster = 1'b1;
    endtask

    task automatic test_reset();
        b0 = '0; b1 = '0; b2 = '0; b3 = '0;
        #2;
        rstmaster = 1'b0;
        #1;
        checks++;
        if ({ack_a, we_a, addr_a, wdata_a, busy_a, full_a, ptr_a} !== 87'd0) begin
            failures++;
            $display("[TB] FAIL reset_async_a: got ack=%h we=%b addr=%h wdata=%h busy=%b full=%b ptr=%h, want all zero",
                     ack_a, we_a, addr_a, wdata_a, busy_a, full_a, ptr_a);
        end
        checks++;
        if ({ack_b, we_b, addr_b, wdata_b, busy_b, full_b, ptr_b} !== 87'd0) begin
            failures++;
            $display("[TB] FAIL reset_async_b: got ack=%h we=%b addr=%h wdata=%h busy=%b full=%b ptr=%h, want all zero",
                     ack_b, we_b, addr_b, wdata_b, busy_b, full_b, ptr_b);
        end
        do_reset();
        tick();
        checks++;
        if ({ack_a, we_a, busy_a, ptr_a} !== 22'd0) begin
            failures++;
            $display("[TB] FAIL reset_idle: got ack=%h we=%b busy=%b ptr=%h, want 0", ack_a, we_a, busy_a, ptr_a);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if ({we_a, addr_a, wdata_a, ack_a, busy_a} !== {1'b1, 32'(k), exp_word(2, 16'h0, k), 4'b0, 1'b1}) begin
                failures++;
                $display("[TB] FAIL single_word%0d: got we=%b addr=%h data=%h ack=%h busy=%b, want we=1 addr=%h data=%h ack=0 busy=1",
                         k, we_a, addr_a, wdata_a, ack_a, busy_a, k, exp_word(2, 16'h0, k));
            end
        end
        tick();
        checks++;
        if ({we_a, addr_a, wdata_a, ack_a, ptr_a, full_a, busy_a} !==
            {1'b0, 32'd7, exp_word(2, 16'h0, 7), 4'b0100, 16'd8, 1'b0, 1'b1}) begin
            failures++;
            $display("[TB] FAIL single_ack: got we=%b addr=%h data=%h ack=%b ptr=%0d full=%b busy=%b, want we=0 addr=7 ack=0100 ptr=8 full=0 busy=1",
                     we_a, addr_a, wdata_a, ack_a, ptr_a, full_a, busy_a);
        end
        req = 4'b0000;
        tick();
        checks++;
        if ({ack_a, we_a, busy_a, ptr_a} !== {4'b0, 1'b0, 1'b0, 16'd8}) begin
            failures++;
            $display("[TB] FAIL single_idle: got ack=%b we=%b busy=%b ptr=%0d, want ack=0 we=0 busy=0 ptr=8",
                     ack_a, we_a, busy_a, ptr_a);
        end
    endtask

    task automatic test_fairness();
        int eng;
        do_reset();
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            eng = n % 4;
            for (int k = 0; k < 8; k++) begin
                tick();
                checks++;
                if ({we_a, addr_a, wdata_a} !== {1'b1, 32'(n*8 + k), exp_word(eng, 16'h0, k)}) begin
                    failures++;
                    $display("[TB] FAIL fair_grant%0d_word%0d: got we=%b addr=%0d data=%h, want we=1 addr=%0d data=%h",
                             n, k, we_a, addr_a, wdata_a, n*8 + k, exp_word(eng, 16'h0, k));
                end
            end
            tick();
            checks++;
            if ({ack_a, ptr_a, full_a} !== {4'(1 << eng), 16'(n*8 + 8), 1'b0}) begin
                failures++;
                $display("[TB] FAIL fair_ack%0d: got ack=%b ptr=%0d full=%b, want ack=%b ptr=%0d full=0",
                         n, ack_a, ptr_a, full_a, 4'(1 << eng), n*8 + 8);
            end
            tick();
        end
        req = 4'b0000;
    endtask

    task automatic test_full();
        do_reset();
        req = 4'b0111;
        for (int g = 0; g < 2; g++) begin
            for (int k = 0; k < 8; k++) begin
                tick();
                checks++;
                if ({we_b, addr_b, wdata_b} !== {1'b1, 32'(g*8 + k), exp_word(g, 16'h0, k)}) begin
                    failures++;
                    $display("[TB] FAIL full_bundle%0d_word%0d: got we=%b addr=%0d data=%h, want we=1 addr=%0d data=%h",
                             g, k, we_b, addr_b, wdata_b, g*8 + k, exp_word(g, 16'h0, k));
                end
            end
            tick();
            checks++;
            if ({ack_b, ptr_b, full_b} !== {4'(1 << g), 16'(g*8 + 8), (g == 1)}) begin
                failures++;
                $display("[TB] FAIL full_ack%0d: got ack=%b ptr=%0d full=%b, want ack=%b ptr=%0d full=%b",
                         g, ack_b, ptr_b, full_b, 4'(1 << g), g*8 + 8, g == 1);
            end
            tick();
            req = req & ~4'(1 << g);
        end
        for (int s = 0; s < 4; s++) begin
            tick();
            checks++;
            if ({we_b, busy_b, ack_b, full_b, ptr_b} !== {1'b0, 1'b0, 4'b0, 1'b1, 16'd16}) begin
                failures++;
                $display("[TB] FAIL full_stall%0d: got we=%b busy=%b ack=%b full=%b ptr=%0d, want we=0 busy=0 ack=0 full=1 ptr=16",
                         s, we_b, busy_b, ack_b, full_b, ptr_b);
            end
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if ({we_b, busy_b, full_b, ptr_b} !== {1'b0, 1'b0, 1'b0, 16'd0}) begin
            failures++;
            $display("[TB] FAIL full_clear: got we=%b busy=%b full=%b ptr=%0d, want we=0 busy=0 full=0 ptr=0",
                     we_b, busy_b, full_b, ptr_b);
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if ({we_b, addr_b, wdata_b} !== {1'b1, 32'(k), exp_word(2, 16'h0, k)}) begin
                failures++;
                $display("[TB] FAIL full_third_word%0d: got we=%b addr=%0d data=%h, want we=1 addr=%0d data=%h",
                         k, we_b, addr_b, wdata_b, k, exp_word(2, 16'h0, k));
            end
        end
        tick();
        checks++;
        if ({ack_b, ptr_b, full_b} !== {4'b0100, 16'd8, 1'b0}) begin
            failures++;
            $display("[TB] FAIL full_third_ack: got ack=%b ptr=%0d full=%b, want ack=0100 ptr=8 full=0", ack_b, ptr_b, full_b);
        end
        tick();
        req = 4'b0000;
    endtask

    task automatic test_data_change();
        do_reset();
        b0  = make_bundle(0, 16'hAAAA);
        req = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if ({we_a, addr_a, wdata_a} !== {1'b1, 32'(k), exp_word(0, 16'hAAAA, k)}) begin
                failures++;
                $display("[TB] FAIL change_word%0d: got we=%b addr=%0d data=%h, want we=1 addr=%0d data=%h",
                         k, we_a, addr_a, wdata_a, k, exp_word(0, 16'hAAAA, k));
            end
            if (k == 3) begin
                req = 4'b0000;
                b0  = make_bundle(0, 16'h5555);
            end
        end
        tick();
        checks++;
        if ({ack_a, ptr_a, we_a} !== {4'b0001, 16'd8, 1'b0}) begin
            failures++;
            $display("[TB] FAIL change_ack: got ack=%b ptr=%0d we=%b, want ack=0001 ptr=8 we=0", ack_a, ptr_a, we_a);
        end
        tick();
    endtask

    // Continues from test_data_change: IDLE, wr_ptr=8, last grant 0
    task automatic test_simultaneous();
        clear = 1'b1;
        req   = 4'b0001;
        tick();
        clear = 1'b0;
        checks++;
        if ({we_a, busy_a, ack_a, full_a, ptr_a, addr_a} !== {1'b0, 1'b0, 4'b0, 1'b0, 16'd0, 32'd7}) begin
            failures++;
            $display("[TB] FAIL simul_clear: got we=%b busy=%b ack=%b full=%b ptr=%0d addr=%0d, want we=0 busy=0 ack=0 full=0 ptr=0 addr=7",
                     we_a, busy_a, ack_a, full_a, ptr_a, addr_a);
        end
        tick();
        req = 4'b0000;
        checks++;
        if ({we_a, addr_a, wdata_a, busy_a} !== {1'b1, 32'd0, exp_word(0, 16'h5555, 0), 1'b1}) begin
            failures++;
            $display("[TB] FAIL simul_grant: got we=%b addr=%0d data=%h busy=%b, want we=1 addr=0 data=%h busy=1",
                     we_a, addr_a, wdata_a, busy_a, exp_word(0, 16'h5555, 0));
        end
        repeat (7) tick();
        tick();
        checks++;
        if ({ack_a, ptr_a} !== {4'b0001, 16'd8}) begin
            failures++;
            $display("[TB] FAIL simul_ack: got ack=%b ptr=%0d, want ack=0001 ptr=8", ack_a, ptr_a);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0001;
        for (int k = 0; k < 6; k++) tick();
        checks++;
        if ({we_a, addr_a, wdata_a} !== {1'b1, 32'd5, exp_word(0, 16'h0, 5)}) begin
            failures++;
            $display("[TB] FAIL mid_word5: got we=%b addr=%0d data=%h, want we=1 addr=5 data=%h",
                     we_a, addr_a, wdata_a, exp_word(0, 16'h0, 5));
        end
        #2;
        rstmaster = 1'b0;
        #1;
        checks++;
        if ({ack_a, we_a, addr_a, wdata_a, busy_a, full_a, ptr_a} !== 87'd0) begin
            failures++;
            $display("[TB] FAIL mid_async: got ack=%b we=%b addr=%h data=%h busy=%b full=%b ptr=%0d, want all zero",
                     ack_a, we_a, addr_a, wdata_a, busy_a, full_a, ptr_a);
        end
        req = 4'b0000;
        repeat (3) begin
            tick();
            checks++;
            if ({ack_a, we_a} !== 5'd0) begin
                failures++;
                $display("[TB] FAIL mid_no_ack: got ack=%b we=%b, want ack=0 we=0", ack_a, we_a);
            end
        end
        @(negedge clk);
        rstmaster = 1'b1;
        req = 4'b1000;
        tick();
        req = 4'b0000;
        checks++;
        if ({we_a, addr_a, wdata_a, busy_a} !== {1'b1, 32'd0, exp_word(3, 16'h0, 0), 1'b1}) begin
            failures++;
            $display("[TB] FAIL mid_regrant: got we=%b addr=%0d data=%h busy=%b, want we=1 addr=0 data=%h busy=1",
                     we_a, addr_a, wdata_a, busy_a, exp_word(3, 16'h0, 0));
        end
        repeat (7) tick();
        tick();
        checks++;
        if ({ack_a, ptr_a} !== {4'b1000, 16'd8}) begin
            failures++;
            $display("[TB] FAIL mid_ack: got ack=%b ptr=%0d, want ack=1000 ptr=8", ack_a, ptr_a);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_full();
        test_data_change();
        test_simultaneous();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
